// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC select codes,
// FSM states and the alignment helper.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4,
    PC_TRAP   = 3'd5
  } pc_sel_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  // Alignment bits for the default 4-byte step.
  localparam int ALIGN_BITS = $clog2(4);

  // Low-bit mask used to detect a misaligned target for a given step.
  function automatic logic [31:0] align_mask(input int step);
    return 32'(step - 1);
  endfunction

endpackage

// File: rtl/pc_unit_return_stack.sv
// Circular return-address LIFO. A push onto a full stack overwrites the
// oldest entry and the count saturates. The caller never pops when empty.
module return_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;   // next slot to write
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_ptr_inc, w_ptr_dec;

  assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign w_ptr_dec = (r_ptr == '0) ? PW'(DEPTH - 1) : r_ptr - 1'b1;
  assign pop_data  = r_mem[w_ptr_dec];
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CW'(DEPTH));

  // Pointer and occupancy; push wins if both were ever asserted.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr <= w_ptr_inc;
      if (!full) r_cnt <= r_cnt + 1'b1;
    end else if (pop && !empty) begin
      r_ptr <= w_ptr_dec;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Entry storage needs no reset; occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with internal next-PC selection, stall hold, one-cycle
// boot phase, alignment trap and optional return-address stack.
// Optional feature macro: PC_UNIT_RAS_EN (return stack for CALL/RET).
module pc_unit
  import pc_pkg::*;
#(
  parameter int           W         = 32,
  parameter int           STEP      = 4,
  parameter logic [W-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [W-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int           RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         stall,
  input  logic [2:0]   sel,
  input  logic         br_taken,
  input  logic [W-1:0] offset,
  input  logic [W-1:0] target,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus,
  output logic         pc_valid,
  output logic         misalign,
  output logic         ras_err
);

  localparam logic [W-1:0] MASK = W'(align_mask(STEP));

  pc_state_t    r_state;
  logic [W-1:0] r_pc;
  logic         r_valid, r_mis, r_rerr;
  logic [W-1:0] w_cand, w_next;
  logic         w_check, w_mis, w_rerr, w_adv;

  assign w_adv   = (r_state == RUN) && !stall;
  assign pc      = r_pc;
  assign pc_plus = r_pc + W'(STEP);
  assign pc_valid = r_valid;
  assign misalign = r_mis;

`ifdef PC_UNIT_RAS_EN
  logic         w_push, w_pop, w_empty, w_unused_full;
  logic [W-1:0] w_pop_data;

  return_stack #(.W(W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .clr_n     (clr_n),
    .push      (w_push && w_adv),
    .pop       (w_pop && w_adv),
    .push_data (pc_plus),
    .pop_data  (w_pop_data),
    .empty     (w_empty),
    .full      (w_unused_full)
  );
  assign ras_err = r_rerr;
`else
  assign ras_err = 1'b0;
`endif

  // Candidate target per select code, then alignment substitution.
  always_comb begin
    w_cand  = pc_plus;
    w_check = 1'b1;
    w_rerr  = 1'b0;
`ifdef PC_UNIT_RAS_EN
    w_push  = 1'b0;
    w_pop   = 1'b0;
`endif
    case (sel)
      PC_BRANCH: if (br_taken) w_cand = r_pc + offset;
      PC_JUMP:   w_cand = target;
      PC_CALL: begin
        w_cand = target;
`ifdef PC_UNIT_RAS_EN
        w_push = 1'b1;
`endif
      end
      PC_RET: begin
`ifdef PC_UNIT_RAS_EN
        if (w_empty) begin
          w_cand  = TRAP_VEC;
          w_check = 1'b0;
          w_rerr  = 1'b1;
        end else begin
          w_cand = w_pop_data;
          w_pop  = 1'b1;
        end
`else
        w_cand = target;
`endif
      end
      PC_TRAP: begin
        w_cand  = TRAP_VEC;
        w_check = 1'b0;
      end
      default: ;
    endcase
    w_mis  = w_check && ((w_cand & MASK) != '0);
    w_next = w_mis ? TRAP_VEC : w_cand;
  end

  // Boot/run sequencing, PC update and single-cycle error pulses.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_rerr  <= 1'b0;
    end else if (r_state == BOOT) begin
      r_state <= RUN;
      r_valid <= 1'b1;
      r_mis   <= 1'b0;
      r_rerr  <= 1'b0;
    end else if (stall) begin
      r_mis   <= 1'b0;
      r_rerr  <= 1'b0;
    end else begin
      r_pc    <= w_next;
      r_mis   <= w_mis;
      r_rerr  <= w_rerr;
    end
  end

`ifndef PC_UNIT_RAS_EN
  logic w_unused_rerr;
  assign w_unused_rerr = r_rerr;
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-register program counter: it owns next-PC selection internally instead of latching an external address.
- Computes sequential, PC-relative branch, absolute jump, call/return and trap targets, with stall hold and a one-cycle boot phase.
- Sits between control unit/branch comparator and instruction memory; drives the fetch address plus a valid flag.

Parameters:
- W, 32, PC/address width in bits
- STEP, 4, sequential increment in bytes; power of two; also the alignment unit
- RESET_VEC, 32'h0000_0000, PC value while in reset and during BOOT
- TRAP_VEC, 32'h0000_0100, redirect target on misalignment or return-stack underflow
- RAS_DEPTH, 4, return-address-stack entries (used only with RAS_EN)

Ports:
- clk  in  1  system clock, rising-edge
- clr_n  in  1  asynchronous, active-low reset; the block's single clock and reset
- stall  in  1  hold PC and all state this cycle
- sel  in  3  next-PC select, pc_sel_t: SEQ=0, BRANCH=1, JUMP=2, CALL=3, RET=4, TRAP=5; codes 6 and 7 behave as SEQ
- br_taken  in  1  qualifies BRANCH; 0 gives a sequential step
- offset  in  W  signed byte offset for BRANCH
- target  in  W  absolute target for JUMP, CALL and RET (RET without RAS_EN)
- pc  out  W  current fetch address
- pc_plus  out  W  combinational pc+STEP (link value)
- pc_valid  out  1  pc is a real fetch address
- misalign  out  1  one-cycle pulse: a computed target was misaligned and replaced by TRAP_VEC
- ras_err  out  1  one-cycle pulse: RET on an empty stack (0 without RAS_EN)

Behaviour:
- Reset (clr_n=0, asynchronous):
  - pc=RESET_VEC; pc_valid=0; misalign=0; ras_err=0.
  - State BOOT; return stack emptied.
  - Reset mid-operation aborts immediately, with no partial update.
- FSM:
  - BOOT -> RUN on the first clk edge after clr_n rises; pc stays RESET_VEC across that edge.
  - RUN sets pc_valid=1 and holds it until reset.
  - No other states.
- Priority at each RUN edge: stall > sel.
  - stall=1: pc, stack, pointer and flags hold; sel is ignored; misalign and ras_err drop to 0.
  - stall=1 in BOOT: BOOT -> RUN still occurs.
- Next-PC candidates (all arithmetic modulo 2^W; wrap-around is silent):
  - SEQ: pc+STEP.
  - BRANCH: pc+offset if br_taken, else pc+STEP.
  - JUMP: target.
  - CALL: target; pushes pc_plus.
  - RET: popped entry.
  - TRAP: TRAP_VEC (no alignment check).
- Alignment:
  - If the candidate's low log2(STEP) bits are nonzero, pc loads TRAP_VEC and misalign pulses for one cycle.
  - A misaligned CALL still pushes pc_plus.
- Latency:
  - sel, offset and target are sampled at edge N; the new pc is visible after edge N.
  - pc_plus follows pc combinationally.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- Defined:
  - RAS_DEPTH-entry LIFO of W-bit return addresses, with pointer and count.
  - CALL pushes pc_plus. Push when full overwrites the oldest entry circularly; count saturates; no error.
  - RET pops into pc.
  - RET when empty: pc=TRAP_VEC, ras_err pulses one cycle, pointer unchanged.
- Undefined:
  - CALL behaves as JUMP.
  - RET behaves as JUMP to target.
  - ras_err is tied 0; no stack storage is synthesised.

Decomposition:
- Package pc_pkg: pc_sel_t enum, pc_state_t {BOOT, RUN}, localparam ALIGN_BITS=$clog2(STEP) helper.
- Sub-module: return_stack (push, pop, push data, pop data, empty, full), instantiated only under PC_UNIT_RAS_EN.

Test Plan:
- Reset/boot:
  - clr_n low mid-RUN with pc=0x40 -> pc=0x0 immediately, pc_valid=0.
  - Release clr_n -> pc_valid=1 after the first edge; pc=0x0 during BOOT.
- Sequential and wrap:
  - From pc=0x0, SEQ for 3 edges -> 0x4, 0x8, 0xC.
  - With pc=0xFFFF_FFFC, SEQ -> pc=0x0, misalign=0.
- Branch:
  - pc=0x20, BRANCH, br_taken=1, offset=0xFFFF_FFF0 -> pc=0x10.
  - Same with br_taken=0 -> pc=0x24.
- Stall/misalign:
  - stall=1 with sel=JUMP, target=0x80 -> pc unchanged.
  - Release stall -> pc=0x80.
  - JUMP target=0x82 -> pc=0x100, misalign pulses for 1 cycle.
- RAS (PC_UNIT_RAS_EN):
  - At pc=0x10, CALL target=0x200 -> pc=0x200.
  - RET -> pc=0x14.
  - A second RET -> pc=0x100, ras_err=1.
  - Five CALLs then five RETs (depth 4) -> first four RETs return the last four links, the fifth raises ras_err.
- RAS absent (macro undefined): RET target=0x300 -> pc=0x300, ras_err stays 0.
